// File: rtl/clock_ctrl_pkg.sv
// Shared operation codes and sequencer state encoding for the clock counter control path.
package clock_ctrl_pkg;

    localparam logic [1:0] OP_NONE     = 2'b00;
    localparam logic [1:0] OP_SEC_ZERO = 2'b01;
    localparam logic [1:0] OP_MIN_ADD  = 2'b10;
    localparam logic [1:0] OP_RESET    = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StHold
    } seq_state_e;

    // Fixed priority: full reset, then seconds clear, then minute add.
    function automatic logic [1:0] pick_op(input logic reset_pend, input logic sto0_pend);
        if (reset_pend) begin
            return OP_RESET;
        end else if (sto0_pend) begin
            return OP_SEC_ZERO;
        end
        return OP_MIN_ADD;
    endfunction

endpackage

// File: rtl/op_request_pending.sv
// Pending request store: reset/seconds-clear flags and a saturating minute-add counter.
module op_request_pending
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned MADD_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_madd_i,
    input  logic              req_sto0_i,
    input  logic              req_reset_i,
    input  logic              grant_i,
    input  logic [1:0]        grant_op_i,
    output logic              reset_pend_o,
    output logic              sto0_pend_o,
    output logic [MADD_W-1:0] madd_cnt_o
);

    localparam logic [MADD_W-1:0] MaddMax = '1;
    localparam logic [MADD_W-1:0] MaddOne = MADD_W'(1);

    logic              reset_pend_q, reset_pend_d;
    logic              sto0_pend_q, sto0_pend_d;
    logic [MADD_W-1:0] madd_q, madd_d;
    logic              g_reset, g_sto0, g_madd, madd_inc;

    always_comb begin
        g_reset = grant_i && (grant_op_i == OP_RESET);
        g_sto0  = grant_i && (grant_op_i == OP_SEC_ZERO);
        g_madd  = grant_i && (grant_op_i == OP_MIN_ADD);

        // A request in the grant cycle keeps the item pending.
        reset_pend_d = req_reset_i || (reset_pend_q && !g_reset);
        sto0_pend_d  = req_sto0_i || (sto0_pend_q && !g_sto0 && !req_reset_i);

        // At saturation an increment is only accepted when a decrement frees a slot.
        madd_inc = req_madd_i && ((madd_q != MaddMax) || g_madd);
        madd_d   = madd_q;
        if (req_reset_i) begin
            madd_d = '0;
        end else if (g_madd && !madd_inc) begin
            madd_d = madd_q - MaddOne;
        end else if (madd_inc && !g_madd) begin
            madd_d = madd_q + MaddOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reset_pend_q <= 1'b0;
            sto0_pend_q  <= 1'b0;
            madd_q       <= '0;
        end else begin
            reset_pend_q <= reset_pend_d;
            sto0_pend_q  <= sto0_pend_d;
            madd_q       <= madd_d;
        end
    end

    assign reset_pend_o = reset_pend_q;
    assign sto0_pend_o  = sto0_pend_q;
    assign madd_cnt_o   = madd_q;

endmodule

// File: rtl/clock_op_sequencer.sv
// Arbitrates pending user commands and issues them one at a time as single-cycle op codes,
// waiting for the counter's acknowledge and a short hold-off between operations.
module clock_op_sequencer
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned MADD_W      = 4,
    parameter int unsigned ACK_TIMEOUT = 4,
    parameter int unsigned HOLDOFF     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_madd_i,
    input  logic              req_sto0_i,
    input  logic              req_reset_i,
    input  logic              op_ack_i,
    output logic [1:0]        operation_o,
    output logic              busy_o,
    output logic [MADD_W-1:0] madd_pending_o,
    output logic              err_timeout_o
);

    localparam int unsigned TimerMax = (ACK_TIMEOUT > HOLDOFF) ? ACK_TIMEOUT : HOLDOFF;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam logic [TimerW-1:0] AckLast  = TimerW'(ACK_TIMEOUT - 1);
    localparam logic [TimerW-1:0] HoldLast = TimerW'(HOLDOFF - 1);
    localparam logic [TimerW-1:0] TimerOne = TimerW'(1);

    seq_state_e        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        op_q, op_d;
    logic              err_q, err_d;

    logic              reset_pend, sto0_pend, any_pend, grant;
    logic [MADD_W-1:0] madd_cnt;
    logic [1:0]        grant_op;

    op_request_pending #(
        .MADD_W (MADD_W)
    ) u_pending (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_madd_i   (req_madd_i),
        .req_sto0_i   (req_sto0_i),
        .req_reset_i  (req_reset_i),
        .grant_i      (grant),
        .grant_op_i   (grant_op),
        .reset_pend_o (reset_pend),
        .sto0_pend_o  (sto0_pend),
        .madd_cnt_o   (madd_cnt)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        op_d     = OP_NONE;
        err_d    = err_q;
        grant    = 1'b0;
        grant_op = pick_op(reset_pend, sto0_pend);
        any_pend = reset_pend || sto0_pend || (madd_cnt != '0);

        unique case (state_q)
            StIdle: begin
                if (any_pend) begin
                    grant   = 1'b1;
                    op_d    = grant_op;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitAck;
                timer_d = '0;
            end
            StWaitAck: begin
                // Abandoned ops are not retried; only the sticky flag records them.
                if (op_ack_i) begin
                    state_d = StHold;
                    timer_d = '0;
                end else if (timer_q == AckLast) begin
                    err_d   = 1'b1;
                    state_d = StHold;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            StHold: begin
                if (timer_q == HoldLast) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            timer_q <= '0;
            op_q    <= OP_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign operation_o    = op_q;
    assign busy_o         = (state_q != StIdle);
    assign madd_pending_o = madd_cnt;
    assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_clock_op_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-age reference model.
module tb_clock_op_sequencer;

    localparam int MADD_W      = 4;
    localparam int ACK_TIMEOUT = 4;
    localparam int HOLDOFF     = 2;
    localparam int MADD_MAX    = 15;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_madd_i = 1'b0;
    logic              req_sto0_i = 1'b0;
    logic              req_reset_i = 1'b0;
    logic              op_ack_i = 1'b0;
    logic [1:0]        operation_o;
    logic              busy_o;
    logic [MADD_W-1:0] madd_pending_o;
    logic              err_timeout_o;

    clock_op_sequencer #(
        .MADD_W      (MADD_W),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .HOLDOFF     (HOLDOFF)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_madd_i     (req_madd_i),
        .req_sto0_i     (req_sto0_i),
        .req_reset_i    (req_reset_i),
        .op_ack_i       (op_ack_i),
        .operation_o    (operation_o),
        .busy_o         (busy_o),
        .madd_pending_o (madd_pending_o),
        .err_timeout_o  (err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending items as plain integers, sequencer as "age since issue".
    bit         m_idle = 1'b1;
    int         m_age = 0;
    int         m_res = -1;
    int         m_madd = 0;
    bit         m_rp = 1'b0;
    bit         m_sp = 1'b0;
    bit         m_err = 1'b0;
    logic [1:0] m_op = 2'b00;

    logic [1:0] prev_op = 2'b00;
    logic [1:0] last_dut_op = 2'b00;
    bit         ack_en = 1'b1;
    int         max_madd_seen = 0;
    logic [1:0] opq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit madd, input bit sto0, input bit rreset,
                              input bit ack);
        logic [1:0] code;
        code = 2'b00;
        if (rst) begin
            m_idle = 1'b1; m_age = 0; m_res = -1; m_madd = 0;
            m_rp = 1'b0; m_sp = 1'b0; m_err = 1'b0; m_op = 2'b00;
            return;
        end
        if (m_idle) begin
            if (m_rp) begin
                code = 2'b11; m_rp = 1'b0;
            end else if (m_sp) begin
                code = 2'b01; m_sp = 1'b0;
            end else if (m_madd > 0) begin
                code = 2'b10; m_madd--;
            end
        end
        if (rreset) begin
            m_rp = 1'b1; m_sp = 1'b0; m_madd = 0;
        end
        if (sto0) m_sp = 1'b1;
        if (madd && !rreset && m_madd < MADD_MAX) m_madd++;

        if (m_idle) begin
            m_op = code;
            if (code != 2'b00) begin
                m_idle = 1'b0; m_age = 0; m_res = -1;
            end
        end else begin
            m_op = 2'b00;
            if (m_res < 0) begin
                if (m_age >= 1 && (ack || m_age == ACK_TIMEOUT)) begin
                    m_res = m_age;
                    if (!ack) m_err = 1'b1;
                end
            end else if (m_age == m_res + HOLDOFF) begin
                m_idle = 1'b1;
            end
            m_age++;
        end
    endtask

    // One clock cycle: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic tick(input bit rst, input bit madd, input bit sto0, input bit rreset,
                        input bit ack_force);
        bit ack;
        ack = ack_force || (ack_en && prev_op != 2'b00);
        rst_i = rst; req_madd_i = madd; req_sto0_i = sto0; req_reset_i = rreset; op_ack_i = ack;
        @(posedge clk_i);
        prev_op = m_op;
        model_step(rst, madd, sto0, rreset, ack);
        #1;
        check_eq("operation", {30'd0, operation_o}, {30'd0, m_op});
        check_eq("busy", {31'd0, busy_o}, {31'd0, !m_idle});
        check_eq("madd_pending", {28'd0, madd_pending_o}, m_madd);
        check_eq("err_timeout", {31'd0, err_timeout_o}, {31'd0, m_err});
        check_eq("no_back_to_back", {31'd0, (operation_o != 2'b00) && (last_dut_op != 2'b00)},
                 32'd0);
        last_dut_op = operation_o;
        if (operation_o != 2'b00) opq.push_back(operation_o);
        if (int'(madd_pending_o) > max_madd_seen) max_madd_seen = int'(madd_pending_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_busy", {31'd0, busy_o}, 32'd0);
        check_eq("reset_op", {30'd0, operation_o}, 32'd0);
        idle(4);

        // Single minute add, acked
        opq.delete();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("s1_busy_before_issue", {31'd0, busy_o}, 32'd1);
        idle(10);
        check_eq("s1_issues", opq.size(), 1);
        check_eq("s1_madd_zero", {28'd0, madd_pending_o}, 32'd0);

        // Five consecutive minute adds
        opq.delete();
        repeat (5) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(30);
        check_eq("s2_issues", opq.size(), 5);

        // Twenty adds with ack held low: saturation and timeout
        ack_en = 1'b0;
        max_madd_seen = 0;
        repeat (20) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("s3_saturate", max_madd_seen, MADD_MAX);
        idle(140);
        check_eq("s3_err_sticky", {31'd0, err_timeout_o}, 32'd1);
        check_eq("s3_drained", {28'd0, madd_pending_o}, 32'd0);

        // Reset while waiting for ack; a late ack must be ignored
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("s6_busy", {31'd0, busy_o}, 32'd0);
        check_eq("s6_err_cleared", {31'd0, err_timeout_o}, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("s6_late_ack", {31'd0, busy_o}, 32'd0);
        ack_en = 1'b1;
        idle(3);

        // Three adds, then seconds-clear and full reset together
        opq.delete();
        repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(25);
        check_eq("s4_count", opq.size(), 3);
        if (opq.size() == 3) begin
            check_eq("s4_first", {30'd0, opq[0]}, 32'd2);
            check_eq("s4_second", {30'd0, opq[1]}, 32'd3);
            check_eq("s4_third", {30'd0, opq[2]}, 32'd1);
        end

        // Seconds-clear re-requested in its own grant cycle
        opq.delete();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(15);
        check_eq("s5_count", opq.size(), 2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(49) == 0) ack_en = !ack_en;
            tick($urandom_range(127) == 0, $urandom_range(3) == 0, $urandom_range(15) == 0,
                 $urandom_range(31) == 0, $urandom_range(19) == 0);
        end
        ack_en = 1'b1;
        idle(200);
        check_eq("final_idle", {31'd0, busy_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
